// File: rtl/alu_cmd_sequencer.sv
// Byte-serial command front end for the 7-bit combinational ALU.
// Takes a three-byte frame (header/op select, operand A, operand B) and
// registers the operands and op select for the ALU. It then captures the
// ALU result and flags and returns them as a two-byte response frame.
module alu_cmd_sequencer (
  input  logic       clk,
  input  logic       rst,
  // Command byte stream
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  // Registered ALU inputs
  output logic [6:0] alu_a,
  output logic [6:0] alu_b,
  output logic [2:0] alu_opsel,
  // Combinational ALU outputs
  input  logic [6:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  input  logic       alu_zero,
  input  logic       alu_negative,
  // Response byte stream
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  // Status
  output logic       busy,
  output logic [7:0] err_count
);

  typedef enum logic [2:0] {
    StHdr,
    StA,
    StB,
    StExec,
    StRes,
    StFlg
  } state_e;

  state_e     state_q, state_d;
  logic [6:0] a_q, a_d;
  logic [6:0] b_q, b_d;
  logic [2:0] opsel_q, opsel_d;
  logic [6:0] result_q, result_d;
  logic [3:0] flags_q, flags_d;  // {N, Z, V, C}
  logic [7:0] err_q, err_d;

  logic in_xfer;
  logic out_xfer;
  logic hdr_ok;

  // Handshake qualifiers and header format decode
  always_comb begin
    in_ready  = (state_q == StHdr) || (state_q == StA) || (state_q == StB);
    out_valid = (state_q == StRes) || (state_q == StFlg);
    in_xfer   = in_valid && in_ready;
    out_xfer  = out_valid && out_ready;
    hdr_ok    = in_data[7] && (in_data[6:3] == 4'b0000);
  end

  // Next-state logic and register load enables
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    opsel_d  = opsel_q;
    result_d = result_q;
    flags_d  = flags_q;
    err_d    = err_q;
    unique case (state_q)
      StHdr: begin
        if (in_xfer) begin
          if (hdr_ok) begin
            opsel_d = in_data[2:0];
            state_d = StA;
          end else if (err_q != 8'hFF) begin
            // Malformed header is consumed and dropped; counter saturates
            err_d = err_q + 8'd1;
          end
        end
      end
      StA: begin
        if (in_xfer) begin
          a_d     = in_data[6:0];
          state_d = StB;
        end
      end
      StB: begin
        if (in_xfer) begin
          b_d     = in_data[6:0];
          state_d = StExec;
        end
      end
      StExec: begin
        // ALU inputs settled for a full cycle; capture its outputs
        result_d = alu_result;
        flags_d  = {alu_negative, alu_zero, alu_overflow, alu_carry};
        state_d  = StRes;
      end
      StRes: begin
        if (out_xfer) state_d = StFlg;
      end
      StFlg: begin
        if (out_xfer) state_d = StHdr;
      end
      default: state_d = StHdr;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StHdr;
      a_q      <= 7'd0;
      b_q      <= 7'd0;
      opsel_q  <= 3'd0;
      result_q <= 7'd0;
      flags_q  <= 4'd0;
      err_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      opsel_q  <= opsel_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
    end
  end

  // Response byte mux; sources are registers, so data holds under backpressure
  always_comb begin
    out_data = 8'h00;
    unique case (state_q)
      StRes:   out_data = {1'b0, result_q};
      StFlg:   out_data = {4'b0000, flags_q};
      default: out_data = 8'h00;
    endcase
  end

  // Output assignments
  always_comb begin
    alu_a     = a_q;
    alu_b     = b_q;
    alu_opsel = opsel_q;
    busy      = (state_q != StHdr);
    err_count = err_q;
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a reference ALU and a response scoreboard.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic [6:0] alu_a, alu_b;
  logic [2:0] alu_opsel;
  logic [6:0] alu_result;
  logic       alu_carry, alu_overflow, alu_zero, alu_negative;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic       busy;
  logic [7:0] err_count;

  int checks = 0;
  int passes = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  alu_cmd_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_opsel    (alu_opsel),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .alu_zero     (alu_zero),
    .alu_negative (alu_negative),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .busy         (busy),
    .err_count    (err_count)
  );

  // Reference ALU: returns {N, Z, V, C, result[6:0]}
  function automatic logic [10:0] alu_ref(input logic [6:0] a, input logic [6:0] b,
                                          input logic [2:0] op);
    logic [7:0] w;
    logic [6:0] r;
    logic       c, v;
    w = 8'h00;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[6:0];
        c = w[7];
        v = (a[6] == b[6]) && (r[6] != a[6]);
      end
      3'd1: begin
        w = {1'b0, a} - {1'b0, b};
        r = w[6:0];
        c = w[7];
        v = (a[6] != b[6]) && (r[6] != a[6]);
      end
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      default: r = a;
    endcase
    return {r[6], (r == 7'd0), v, c, r};
  endfunction

  assign {alu_negative, alu_zero, alu_overflow, alu_carry, alu_result} =
      alu_ref(alu_a, alu_b, alu_opsel);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one byte and hold it until the sequencer accepts it (bounded)
  task automatic send_byte(input logic [7:0] b);
    logic done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check("in_ready_timeout", {31'd0, done}, 32'd1);
  endtask

  // Wait (bounded) for a response byte and compare it with the scoreboard
  task automatic recv_byte(input string tag);
    logic       got;
    logic [7:0] exp;
    got       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!got) begin
      check({tag, "_timeout"}, {31'd0, got}, 32'd1);
    end else begin
      exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      check(tag, {24'd0, out_data}, {24'd0, exp});
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_expect(input logic [6:0] a, input logic [6:0] b, input logic [2:0] op);
    logic [10:0] r;
    r = alu_ref(a, b, op);
    sb.push_back({1'b0, r[6:0]});
    sb.push_back({4'b0000, r[10:7]});
  endtask

  initial begin
    logic [10:0] rr;
    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_alu_a", {25'd0, alu_a}, 32'd0);
    check("rst_alu_b", {25'd0, alu_b}, 32'd0);
    check("rst_opsel", {29'd0, alu_opsel}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_err", {24'd0, err_count}, 32'd0);

    // Frame 1: 5 + 3, with exact latency checks
    send_byte(8'h80);
    check("f1_opsel", {29'd0, alu_opsel}, 32'd0);
    check("f1_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h05);
    check("f1_alu_a", {25'd0, alu_a}, 32'd5);
    send_byte(8'h03);
    sb.push_back(8'h08);
    sb.push_back(8'h00);
    check("f1_alu_b", {25'd0, alu_b}, 32'd3);
    check("f1_exec_no_valid", {31'd0, out_valid}, 32'd0);
    check("f1_exec_no_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("f1_valid_after_1", {31'd0, out_valid}, 32'd1);
    recv_byte("f1_result");
    check("f1_flg_valid", {31'd0, out_valid}, 32'd1);
    recv_byte("f1_flags");
    check("f1_in_ready_back", {31'd0, in_ready}, 32'd1);
    check("f1_busy_clear", {31'd0, busy}, 32'd0);

    // Frame 2: 7F + 01 wraps, with 5 cycles of backpressure in RES
    out_ready = 1'b0;
    send_byte(8'h80);
    send_byte(8'h7F);
    send_byte(8'h01);
    sb.push_back(8'h00);
    sb.push_back(8'h05);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h00;
      @(negedge clk);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_data", {24'd0, out_data}, {24'd0, sb[0]});
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    check("bp_err_unchanged", {24'd0, err_count}, 32'd0);
    recv_byte("f2_result");
    recv_byte("f2_flags");

    // Malformed headers are dropped and counted; a valid one follows
    send_byte(8'h05);
    check("bad1_err", {24'd0, err_count}, 32'd1);
    check("bad1_hdr", {31'd0, busy}, 32'd0);
    send_byte(8'h88);
    check("bad2_err", {24'd0, err_count}, 32'd2);
    check("bad2_hdr", {31'd0, busy}, 32'd0);
    send_byte(8'h81);
    check("good_opsel", {29'd0, alu_opsel}, 32'd1);
    check("good_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h10);
    send_byte(8'h83);  // bit7 ignored on operands
    check("op_bit7_ignored", {25'd0, alu_b}, 32'd3);
    push_expect(7'h10, 7'h03, 3'd1);
    recv_byte("sub_result");
    recv_byte("sub_flags");

    // Reset after the A byte discards the frame
    out_ready = 1'b1;
    send_byte(8'h84);
    send_byte(8'h22);
    check("mid_alu_a", {25'd0, alu_a}, 32'h22);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_alu_a_clr", {25'd0, alu_a}, 32'd0);
    check("mid_err_clr", {24'd0, err_count}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_no_resp", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    send_byte(8'h80);
    send_byte(8'h11);
    send_byte(8'h22);
    push_expect(7'h11, 7'h22, 3'd0);
    recv_byte("fresh_result");
    recv_byte("fresh_flags");

    // Negative-result xor frame exercises the N flag path
    send_byte(8'h84);
    send_byte(8'h40);
    send_byte(8'h01);
    rr = alu_ref(7'h40, 7'h01, 3'd4);
    sb.push_back({1'b0, rr[6:0]});
    sb.push_back({4'b0000, rr[10:7]});
    recv_byte("xor_result");
    recv_byte("xor_flags");

    // Error counter saturation
    for (int i = 0; i < 260; i++) begin
      send_byte(8'h00);
      if (i == 253) check("err_254", {24'd0, err_count}, 32'd254);
      if (i == 254) check("err_255", {24'd0, err_count}, 32'd255);
    end
    check("err_sat", {24'd0, err_count}, 32'hFF);
    check("err_sat_hdr", {31'd0, busy}, 32'd0);
    check("sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
